// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
package bru_pkg;

  localparam int DEF_PC_W     = 36;
  localparam int DEF_MAX_PEND = 3;

  typedef enum logic [2:0] {
    COND_NZ     = 3'b000,
    COND_EZ     = 3'b001,
    COND_LZ     = 3'b010,
    COND_GZ     = 3'b011,
    COND_LE     = 3'b100,
    COND_GE     = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_RESOLVE  = 2'd2,
    ST_REDIRECT = 2'd3
  } bru_state_e;

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluation: selects one ALU flag (or a
// constant) according to the branch condition code.
module bru_cond_eval
  import bru_pkg::*;
(
  input  logic     nz,
  input  logic     ez,
  input  logic     lz,
  input  logic     gz,
  input  logic     le,
  input  logic     ge,
  input  br_cond_e cond,
  output logic     taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NZ:     taken = nz;
      COND_EZ:     taken = ez;
      COND_LZ:     taken = lz;
      COND_GZ:     taken = gz;
      COND_LE:     taken = le;
      COND_GE:     taken = ge;
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches against ALU flags once no compare is in flight,
// then issues a fetch redirect. BRU_PREDICT_EN: redirect only on mispredict.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            nz,
  input  logic            ez,
  input  logic            lz,
  input  logic            gz,
  input  logic            le,
  input  logic            ge,
  input  logic            cmp_dispatch,
  output logic            cmp_ready,
  input  logic            flags_wr,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_target,
  input  logic            br_pred,
  input  logic            flush,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [PC_W-1:0] redir_pc
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);

  bru_state_e      state_reg, state_next;
  logic [CNT_W-1:0] pend_cnt_reg, pend_cnt_next;
  br_cond_e        cond_reg;
  logic [PC_W-1:0] target_reg;
  logic            taken_reg;
  logic            taken_eval;
  logic            pend_not_full;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            accept;
  logic            eval_go;
  logic            need_redir;
  logic [PC_W-1:0] redir_addr;

  // Compare scoreboard: a dispatch into a full counter still counts when a
  // flag write frees a slot in the same cycle, so the pair nets to zero.
  assign pend_not_full = (pend_cnt_reg < PEND_MAX);
  assign cnt_inc       = cmp_dispatch && (pend_not_full || flags_wr);
  assign cnt_dec       = flags_wr && (pend_cnt_reg != '0);
  assign cmp_ready     = rst_n && pend_not_full;

  always_comb begin
    pend_cnt_next = pend_cnt_reg;
    if (cnt_inc && !cnt_dec) begin
      pend_cnt_next = pend_cnt_reg + CNT_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      pend_cnt_next = pend_cnt_reg - CNT_W'(1);
    end
  end

  assign accept  = (state_reg == ST_IDLE) && br_valid && !flush;
  assign eval_go = (state_reg == ST_WAIT) && (pend_cnt_reg == '0) && !flags_wr;

  bru_cond_eval u_cond_eval (
    .nz    (nz),
    .ez    (ez),
    .lz    (lz),
    .gz    (gz),
    .le    (le),
    .ge    (ge),
    .cond  (cond_reg),
    .taken (taken_eval)
  );

`ifdef BRU_PREDICT_EN
  logic [PC_W-1:0] pc_reg;
  logic            pred_reg;
  logic [PC_W-1:0] fallthrough;

  // Word-addressed PC: the next sequential instruction wraps at 2^PC_W.
  assign fallthrough = pc_reg + PC_W'(1);
  assign need_redir  = taken_reg ^ pred_reg;
  assign redir_addr  = taken_reg ? target_reg : fallthrough;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg   <= '0;
      pred_reg <= 1'b0;
    end else if (accept) begin
      pc_reg   <= br_pc;
      pred_reg <= br_pred;
    end
  end
`else
  logic [PC_W:0] unused_inputs;

  assign unused_inputs = {br_pc, br_pred};
  assign need_redir    = taken_reg;
  assign redir_addr    = target_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pend_cnt_reg <= '0;
      cond_reg     <= COND_NEVER;
      target_reg   <= '0;
      taken_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_cnt_reg <= pend_cnt_next;
      if (accept) begin
        cond_reg   <= br_cond_e'(br_cond);
        target_reg <= br_target;
      end
      if (eval_go) begin
        taken_reg <= taken_eval;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    br_ready      = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    redir_valid   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        br_ready = 1'b1;
        if (br_valid) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (eval_go) begin
          state_next = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        resolve_valid = 1'b1;
        resolve_taken = taken_reg;
        if (need_redir) begin
          redir_valid = 1'b1;
          state_next  = redir_ready ? ST_IDLE : ST_REDIRECT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Flush abandons the branch; it must not be reported as resolved.
    if (flush) begin
      state_next    = ST_IDLE;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
      redir_valid   = 1'b0;
    end

    if (!rst_n) begin
      br_ready      = 1'b0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
      redir_valid   = 1'b0;
    end
  end

  assign redir_pc = redir_valid ? redir_addr : '0;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus pushes expected resolves and
// redirects into queues, a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

  localparam int PC_W = 36;

  logic            clk;
  logic            rst_n;
  logic            nz, ez, lz, gz, le, ge;
  logic            cmp_dispatch;
  logic            cmp_ready;
  logic            flags_wr;
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] br_target;
  logic            br_pred;
  logic            flush;
  logic            resolve_valid;
  logic            resolve_taken;
  logic            redir_valid;
  logic            redir_ready;
  logic [PC_W-1:0] redir_pc;

  branch_resolve_unit #(.PC_W(PC_W), .MAX_PEND(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .nz            (nz),
    .ez            (ez),
    .lz            (lz),
    .gz            (gz),
    .le            (le),
    .ge            (ge),
    .cmp_dispatch  (cmp_dispatch),
    .cmp_ready     (cmp_ready),
    .flags_wr      (flags_wr),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_cond       (br_cond),
    .br_pc         (br_pc),
    .br_target     (br_target),
    .br_pred       (br_pred),
    .flush         (flush),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit taken;
    int at;
  } res_t;

  res_t            res_q[$];
  logic [PC_W-1:0] redir_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a branch for one cycle; the DUT must be idle in this cycle.
  task automatic issue(input logic [2:0] cond, input logic [PC_W-1:0] pc,
                       input logic [PC_W-1:0] tgt, input logic pred,
                       input int res_delay, input bit expect_res, input bit exp_taken);
    br_valid  = 1'b1;
    br_cond   = cond;
    br_pc     = pc;
    br_target = tgt;
    br_pred   = pred;
    if (expect_res) res_q.push_back('{taken: exp_taken, at: cyc + res_delay});
    tick();
    br_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    res_t            e;
    logic [PC_W-1:0] p;
    if (rst_n && resolve_valid) begin
      if (res_q.size() == 0) begin
        chk("unexpected_resolve", 64'd1, 64'd0);
      end else begin
        e = res_q.pop_front();
        chk("resolve_taken", resolve_taken, e.taken);
        chk("resolve_cycle", cyc, e.at);
      end
      $display("resolve cyc=%0d taken=%0b", cyc, resolve_taken);
    end
    if (rst_n && redir_valid && redir_ready) begin
      if (redir_q.size() == 0) begin
        chk("unexpected_redirect", 64'd1, 64'd0);
      end else begin
        p = redir_q.pop_front();
        chk("redir_pc", redir_pc, p);
      end
      $display("redirect cyc=%0d pc=%0h", cyc, redir_pc);
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_br_ready"}, br_ready, 0);
    chk({tag, "_cmp_ready"}, cmp_ready, 0);
    chk({tag, "_resolve_valid"}, resolve_valid, 0);
    chk({tag, "_redir_valid"}, redir_valid, 0);
    chk({tag, "_redir_pc"}, redir_pc, 0);
  endtask

  initial begin : watchdog
    repeat (5000) @(posedge clk);
    chk("watchdog_timeout", 64'd1, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  logic [7:0] tk_tbl;

  initial begin : stim
    rst_n = 1'b0;
    {nz, ez, lz, gz, le, ge} = 6'b0;
    cmp_dispatch = 1'b0;
    flags_wr     = 1'b0;
    br_valid     = 1'b0;
    br_cond      = 3'b0;
    br_pc        = '0;
    br_target    = '0;
    br_pred      = 1'b0;
    flush        = 1'b0;
    redir_ready  = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk_outputs_zero("reset");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_br_ready", br_ready, 1);
    chk("post_reset_cmp_ready", cmp_ready, 1);

    // ez taken branch, redirect held until fetch accepts
    ez = 1'b1;
    redir_ready = 1'b0;
    redir_q.push_back(36'h40);
    issue(3'b001, 36'h10, 36'h40, 1'b0, 2, 1, 1);
    @(negedge clk);
    chk("wait_br_ready", br_ready, 0);
    tick();
    @(negedge clk);
    chk("resolve_redir_valid", redir_valid, 1);
    chk("resolve_redir_pc", redir_pc, 36'h40);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("redir_hold_valid", redir_valid, 1);
      chk("redir_hold_pc", redir_pc, 36'h40);
      chk("redir_hold_br_ready", br_ready, 0);
    end
    tick();
    redir_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_redir_valid", redir_valid, 0);
    chk("post_redir_br_ready", br_ready, 1);
    ez = 1'b0;

    // Spurious flags_wr at zero, then one compare in flight before an lz branch
    flags_wr = 1'b1;
    tick();
    flags_wr = 1'b0;
    cmp_dispatch = 1'b1;
    tick();
    cmp_dispatch = 1'b0;
    redir_q.push_back(36'h123);
    issue(3'b010, 36'h20, 36'h123, 1'b0, 6, 1, 1);
    repeat (3) tick();
    flags_wr = 1'b1;
    tick();
    flags_wr = 1'b0;
    lz = 1'b1;
    repeat (2) tick();
    lz = 1'b0;

    // Scoreboard saturation at three
    cmp_dispatch = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("full_cmp_ready", cmp_ready, 0);
    tick();
    flags_wr = 1'b1;
    @(negedge clk);
    chk("full_after_4th_cmp_ready", cmp_ready, 0);
    tick();
    cmp_dispatch = 1'b0;
    @(negedge clk);
    chk("full_after_both_cmp_ready", cmp_ready, 0);
    tick();
    flags_wr = 1'b0;
    @(negedge clk);
    chk("two_pending_cmp_ready", cmp_ready, 1);
    redir_q.push_back(36'h77);
    issue(3'b110, 36'h70, 36'h77, 1'b0, 4, 1, 1);
    flags_wr = 1'b1;
    repeat (2) tick();
    flags_wr = 1'b0;
    repeat (2) tick();

    // Every condition code against a fixed flag pattern
    {nz, ez, lz, gz, le, ge} = 6'b100101;
    tk_tbl = 8'h69;
    for (int i = 0; i < 8; i++) begin
      if (tk_tbl[i]) redir_q.push_back(PC_W'(36'h200 + i));
      issue(i[2:0], PC_W'(36'h100 + i), PC_W'(36'h200 + i), 1'b0, 2, 1, tk_tbl[i]);
      repeat (2) tick();
    end
    {nz, ez, lz, gz, le, ge} = 6'b0;

    // Never-taken at the top of the address space
`ifdef BRU_PREDICT_EN
    redir_q.push_back(36'h0);
`endif
    issue(3'b111, 36'hF_FFFF_FFFF, 36'h55, 1'b1, 2, 1, 0);
    tick();
    @(negedge clk);
`ifdef BRU_PREDICT_EN
    chk("never_redir_valid", redir_valid, 1);
`else
    chk("never_redir_valid", redir_valid, 0);
`endif
    tick();

    // Always-taken predicted taken
`ifndef BRU_PREDICT_EN
    redir_q.push_back(36'h310);
`endif
    issue(3'b110, 36'h300, 36'h310, 1'b1, 2, 1, 1);
    repeat (2) tick();

    // Flush while stalled in REDIRECT
    redir_ready = 1'b0;
    issue(3'b110, 36'h30, 36'h80, 1'b0, 2, 1, 1);
    tick();
    @(negedge clk);
    chk("flush_case_resolve_redir", redir_valid, 1);
    tick();
    @(negedge clk);
    chk("flush_case_redirect_hold", redir_valid, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_redir_valid", redir_valid, 0);
    chk("post_flush_br_ready", br_ready, 1);
    redir_ready = 1'b1;

    // Reset while a branch waits on two pending compares
    cmp_dispatch = 1'b1;
    repeat (2) tick();
    cmp_dispatch = 1'b0;
    issue(3'b110, 36'h40, 36'h90, 1'b0, 0, 0, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("wait_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_br_ready", br_ready, 1);
    chk("rerelease_cmp_ready", cmp_ready, 1);
    redir_q.push_back(36'hA0);
    issue(3'b110, 36'h50, 36'hA0, 1'b0, 2, 1, 1);
    repeat (5) tick();

    chk("resolve_queue_drained", res_q.size(), 0);
    chk("redirect_queue_drained", redir_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Consumes the six condition flags (nz, ez, lz, gz, le, ge) registered by the scalar ALU on compare ops (op[3]=1) and resolves conditional branches against them. Tracks in-flight compares so a branch never evaluates stale flags. Issues a PC redirect to fetch through a valid/ready handshake. Sits between decode/issue and fetch, alongside the scalar ALU.

## Interface
- PC_W, 36: PC width (word addressed)
- MAX_PEND, 3: max compares in flight between dispatch and flag write
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- nz, ez, lz, gz, le, ge  in  1 each  registered ALU flags
- cmp_dispatch  in  1  a compare op is dispatched toward the ALU this cycle
- cmp_ready  out  1  high when pend_cnt < MAX_PEND; dispatch is legal only when high
- flags_wr  in  1  ALU flag registers load at the end of this cycle
- br_valid  in  1  branch request valid
- br_ready  out  1  high only in IDLE
- br_cond  in  3  000 nz, 001 ez, 010 lz, 011 gz, 100 le, 101 ge, 110 always, 111 never
- br_pc  in  PC_W  PC of the branch
- br_target  in  PC_W  taken target
- br_pred  in  1  predicted taken (used only with BRU_PREDICT_EN)
- flush  in  1  synchronous abort of the current branch
- resolve_valid  out  1  one-cycle pulse: branch resolved
- resolve_taken  out  1  outcome, valid with resolve_valid
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  PC_W  redirect address

## Operation
- States: IDLE, WAIT, RESOLVE, REDIRECT.
- IDLE: br_ready=1. On br_valid&&br_ready, latch cond, pc, target, pred, then go to WAIT.
- WAIT: evaluate when pend_cnt==0 && !flags_wr. Latch taken = selected flag (110→1, 111→0), then go to RESOLVE. Otherwise hold.
- RESOLVE: resolve_valid=1, resolve_taken=taken. If a redirect is needed, assert redir_valid this cycle. If redir_ready is also high, go to IDLE; otherwise go to REDIRECT. If no redirect is needed, go to IDLE.
- REDIRECT: hold redir_valid and redir_pc stable until redir_ready, then go to IDLE.
- Redirect rule (macro off): redirect iff taken, redir_pc = target.
- Fallthrough address = br_pc + 1, mod 2^PC_W (all-ones wraps to 0).
- Scoreboard pend_cnt: +1 on cmp_dispatch, −1 on flags_wr. Both in the same cycle leave it unchanged. flags_wr at 0 is ignored (no underflow). cmp_dispatch with cmp_ready low is ignored (saturate).
- flush: next state IDLE from any state. Drops redir_valid, suppresses resolve_valid in that cycle. pend_cnt is unaffected.
- Reset: state IDLE, pend_cnt 0, all outputs 0 while rst_n low (including br_ready). cmp_ready=1 and br_ready=1 from the first cycle after reset.

## Timing
- Minimum latency with flags settled: accept at cycle 0, WAIT at cycle 1, RESOLVE (resolve_valid, redir_valid) at cycle 2.
- flags_wr in cycle N: evaluation happens no earlier than cycle N+1, using the updated flags.
- Throughput: one branch per 3 cycles maximum; br_ready is low in WAIT, RESOLVE, and REDIRECT.
- redir_valid, once asserted, does not drop until redir_ready, flush, or reset.
- cmp_ready is combinational from pend_cnt only.

## Configuration
- BRU_PREDICT_EN defined: redirect only on mispredict (taken≠pred). On mispredict, redir_pc = target if taken, else br_pc+1. A correct prediction causes no redirect. resolve_valid still pulses.
- BRU_PREDICT_EN undefined: br_pred is ignored; the macro-off rule applies.

## Structure
- Package bru_pkg holds the br_cond_e enum (8 codes above), the bru_state_e enum, and the PC_W/MAX_PEND default localparams.
- Sub-module bru_cond_eval: combinational flags plus br_cond → taken. Instantiated once.

## Test plan
- Flags ez=1, no pending, br_cond=001, br_pc=0x10, target=0x40 → resolve_taken=1 at cycle 2, redir_pc=0x40, redir_valid held until redir_ready.
- cmp_dispatch, then branch lz (010) accepted, flags_wr 4 cycles later with lz=1 → RESOLVE occurs only on the cycle after flags_wr, taken=1.
- Three cmp_dispatch with MAX_PEND=3 → cmp_ready=0. A 4th dispatch is ignored. Simultaneous dispatch+flags_wr keeps the count at 3.
- br_cond=111, br_pc=0xF_FFFF_FFFF → resolve_taken=0, no redirect. With BRU_PREDICT_EN and pred=1 → redir_pc=0.
- flush while in REDIRECT with redir_ready=0 → redir_valid=0 next cycle, br_ready=1.
- Reset asserted in WAIT with pend_cnt=2 → all outputs 0 while rst_n low. After release: IDLE, pend_cnt 0, cmp_ready 1.
